// File: rtl/mult_div_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide unit.
package mult_div_pkg;

   // Default operand / Hi / Lo width.
   localparam int DEF_WIDTH = 32;

   // Operation select encoding on the op input.
   localparam logic OP_MULT = 1'b0;
   localparam logic OP_DIV  = 1'b1;

   // Control states: IDLE waits, MULT/DIV iterate, DONE is the one-cycle completion state.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MULT = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/mult_div_unit_booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of the multiplicand into
// the upper accumulator field, then an arithmetic right shift of the whole
// {A, Q, q-1} accumulator. A is one bit wider than the operands so that the
// most negative multiplicand and zero-extended unsigned operands cannot overflow.
module booth_step
   import mult_div_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [2*WIDTH+1:0] acc_i,
   input  logic [WIDTH:0]     m_i,
   output logic [2*WIDTH+1:0] acc_o
);

   logic [WIDTH:0] a_sum;

   // Booth recode on {Q[0], q-1}, then shift right with sign replication.
   always_comb begin
      a_sum = acc_i[2*WIDTH+1:WIDTH+1];
      case (acc_i[1:0])
         2'b01:   a_sum = acc_i[2*WIDTH+1:WIDTH+1] + m_i;
         2'b10:   a_sum = acc_i[2*WIDTH+1:WIDTH+1] - m_i;
         default: a_sum = acc_i[2*WIDTH+1:WIDTH+1];
      endcase
      acc_o = {a_sum[WIDTH], a_sum, acc_i[WIDTH:1]};
   end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle signed multiply / divide unit holding the MIPS Hi/Lo registers.
// Booth multiply and restoring divide share one {upper, Q, low} accumulator.
// Optional macro MULT_DIV_UNSIGNED_EN adds the is_unsigned input (multu/divu).
// Handshake: start is sampled only in IDLE or DONE; done and div_zero are
// single-cycle pulses; busy is high while iterating; Hi/Lo change only on the
// DONE-entry edge (or reset), so reads during an operation return old values.
module mult_div_unit
   import mult_div_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int ITER  = WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
`ifdef MULT_DIV_UNSIGNED_EN
   input  logic             is_unsigned,
`endif
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             div_zero
);

   localparam int CW = $clog2(ITER + 1);
   localparam int AW = 2 * WIDTH + 2;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [AW-1:0]    acc_q, acc_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic             uns_q, uns_d;
   logic             div_zero_q, div_zero_d;

   logic             uns_in;
`ifdef MULT_DIV_UNSIGNED_EN
   assign uns_in = is_unsigned;
`else
   assign uns_in = 1'b0;
`endif

   // Sign and magnitude views of the incoming dividend and latched operands.
   logic             a_neg_in, a_neg, b_neg;
   logic [WIDTH-1:0] a_mag_in, b_mag;
   logic [WIDTH:0]   m_ext;
   assign a_neg_in = ~uns_in & a[WIDTH-1];
   assign a_mag_in = a_neg_in ? -a : a;
   assign a_neg    = ~uns_q & a_q[WIDTH-1];
   assign b_neg    = ~uns_q & b_q[WIDTH-1];
   assign b_mag    = b_neg ? -b_q : b_q;
   assign m_ext    = uns_q ? {1'b0, a_q} : {a_q[WIDTH-1], a_q};

   logic [AW-1:0] booth_acc;
   booth_step #(.WIDTH(WIDTH)) u_booth (
      .acc_i (acc_q),
      .m_i   (m_ext),
      .acc_o (booth_acc)
   );

   // One restoring-division step: shift the next dividend bit into the
   // remainder, subtract the divisor magnitude, keep it only if non-negative.
   logic [WIDTH:0] div_shift, div_diff;
   logic [AW-1:0]  div_acc;
   always_comb begin
      div_shift = {acc_q[2*WIDTH:WIDTH+1], acc_q[WIDTH]};
      div_diff  = div_shift - {1'b0, b_mag};
      if (!div_diff[WIDTH]) div_acc = {div_diff,  acc_q[WIDTH-1:1], 1'b1, 1'b0};
      else                  div_acc = {div_shift, acc_q[WIDTH-1:1], 1'b0, 1'b0};
   end

   // Final Hi/Lo values. Unsigned multiply folds in the weight of b's top bit
   // that the signed Booth recoding treats as negative.
   logic [WIDTH-1:0] mul_hi, mul_lo, quo, rem, div_hi, div_lo;
   always_comb begin
      mul_lo = acc_q[WIDTH:1];
      mul_hi = acc_q[2*WIDTH:WIDTH+1] + ((uns_q & b_q[WIDTH-1]) ? a_q : '0);
      quo    = acc_q[WIDTH:1];
      rem    = acc_q[2*WIDTH:WIDTH+1];
      div_lo = (a_neg ^ b_neg) ? -quo : quo;
      div_hi = a_neg ? -rem : rem;
   end

   // Control FSM and datapath next-state.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      a_d        = a_q;
      b_d        = b_q;
      uns_d      = uns_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      div_zero_d = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               a_d   = a;
               b_d   = b;
               uns_d = uns_in;
               cnt_d = '0;
               if (op == OP_MULT) begin
                  state_d = MULT;
                  acc_d   = {{(WIDTH + 1){1'b0}}, b, 1'b0};
               end else begin
                  state_d = DIV;
                  acc_d   = {{(WIDTH + 1){1'b0}}, a_mag_in, 1'b0};
               end
            end else begin
               state_d = IDLE;
            end
         end
         MULT: begin
            if (cnt_q == CW'(ITER)) begin
               hi_d    = mul_hi;
               lo_d    = mul_lo;
               state_d = DONE;
            end else begin
               acc_d = booth_acc;
               cnt_d = cnt_q + CW'(1);
            end
         end
         DIV: begin
            if (b_q == '0) begin
               div_zero_d = 1'b1;
               state_d    = DONE;
            end else if (cnt_q == CW'(ITER)) begin
               hi_d    = div_hi;
               lo_d    = div_lo;
               state_d = DONE;
            end else begin
               acc_d = div_acc;
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         acc_q      <= '0;
         a_q        <= '0;
         b_q        <= '0;
         uns_q      <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         div_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         a_q        <= a_d;
         b_q        <= b_d;
         uns_q      <= uns_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         div_zero_q <= div_zero_d;
      end
   end

   assign hi       = hi_q;
   assign lo       = lo_q;
   assign busy     = (state_q == MULT) || (state_q == DIV);
   assign done     = (state_q == DONE);
   assign div_zero = div_zero_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed testbench for mult_div_unit (default signed build).
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        op = 1'b0;
   logic        is_unsigned = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic [31:0] hi, lo;
   logic        busy, done, div_zero;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mult_div_unit dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .op          (op),
`ifdef MULT_DIV_UNSIGNED_EN
      .is_unsigned (is_unsigned),
`endif
      .a           (a),
      .b           (b),
      .hi          (hi),
      .lo          (lo),
      .busy        (busy),
      .done        (done),
      .div_zero    (div_zero)
   );

   // Driver: call #1 after a rising edge. Presents one start, scrambles the
   // operand inputs after the sampling edge E0, then waits (bounded) for done.
   // lat = index k of the edge Ek after which done was seen (0 = timeout).
   task automatic run_op(input logic op_v, input logic [31:0] a_v, input logic [31:0] b_v,
                         output int lat, output logic busy_gap,
                         output logic [31:0] mid_hi, output logic [31:0] mid_lo);
      start = 1'b1; op = op_v; a = a_v; b = b_v;
      @(posedge clk); #1;
      start = 1'b0; a = $urandom; b = $urandom;
      lat = 0; busy_gap = 1'b0; mid_hi = hi; mid_lo = lo;
      for (int k = 1; k <= 60; k++) begin
         @(posedge clk); #1;
         if (done) begin lat = k; break; end
         if (!busy) busy_gap = 1'b1;
         if (k == 16) begin mid_hi = hi; mid_lo = lo; end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want %h", hi, 32'h0); end
      checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want %h", lo, 32'h0); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
      checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_div_zero: got %b want 0", div_zero); end
   endtask

   task automatic test_mult_basic();
      int lat; logic gap; logic [31:0] mh, ml;
      run_op(1'b0, 32'd7, 32'hFFFFFFFD, lat, gap, mh, ml);
      checks++; if (lat !== 33) begin errors++; $display("FAIL mult7_latency: got %0d want 33", lat); end
      checks++; if (gap !== 1'b0) begin errors++; $display("FAIL mult7_busy_gap: got %b want 0", gap); end
      checks++; if (mh !== 32'h0 || ml !== 32'h0) begin errors++; $display("FAIL mult7_midop_hilo: got %h_%h want 0_0", mh, ml); end
      checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult7_hi: got %h want %h", hi, 32'hFFFFFFFF); end
      checks++; if (lo !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult7_lo: got %h want %h", lo, 32'hFFFFFFEB); end
      checks++; if (busy !== 1'b0 || div_zero !== 1'b0) begin errors++; $display("FAIL mult7_done_flags: got busy=%b dz=%b want 0 0", busy, div_zero); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mult7_done_pulse: got done=%b busy=%b want 0 0", done, busy); end
   endtask

   task automatic test_mult_edges();
      int lat; logic gap; logic [31:0] mh, ml;
      run_op(1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, lat, gap, mh, ml);
      checks++; if (mh !== 32'hFFFFFFFF || ml !== 32'hFFFFFFEB) begin errors++; $display("FAIL multmax_midop_hilo: got %h_%h want ffffffff_ffffffeb", mh, ml); end
      checks++; if (hi !== 32'h3FFFFFFF || lo !== 32'h00000001) begin errors++; $display("FAIL multmax_result: got %h_%h want 3fffffff_00000001", hi, lo); end
      @(posedge clk); #1;
      run_op(1'b0, 32'hFFFFFFFB, 32'hFFFFFFFA, lat, gap, mh, ml);
      checks++; if (hi !== 32'h0 || lo !== 32'd30) begin errors++; $display("FAIL multnegneg_result: got %h_%h want 00000000_0000001e", hi, lo); end
      @(posedge clk); #1;
      run_op(1'b0, 32'h80000000, 32'h80000000, lat, gap, mh, ml);
      checks++; if (hi !== 32'h40000000 || lo !== 32'h0) begin errors++; $display("FAIL multminmin_result: got %h_%h want 40000000_00000000", hi, lo); end
      @(posedge clk); #1;
   endtask

   task automatic test_div_signs();
      int lat; logic gap; logic [31:0] mh, ml;
      run_op(1'b1, 32'hFFFFFFF9, 32'd2, lat, gap, mh, ml);
      checks++; if (lat !== 33) begin errors++; $display("FAIL divneg_latency: got %0d want 33", lat); end
      checks++; if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL divneg_result: got hi=%h lo=%h want hi=ffffffff lo=fffffffd", hi, lo); end
      @(posedge clk); #1;
      run_op(1'b1, 32'd7, 32'hFFFFFFFE, lat, gap, mh, ml);
      checks++; if (lo !== 32'hFFFFFFFD || hi !== 32'd1) begin errors++; $display("FAIL divposneg_result: got hi=%h lo=%h want hi=00000001 lo=fffffffd", hi, lo); end
      @(posedge clk); #1;
      run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, lat, gap, mh, ml);
      checks++; if (lo !== 32'h80000000 || hi !== 32'h0) begin errors++; $display("FAIL divovf_result: got hi=%h lo=%h want hi=00000000 lo=80000000", hi, lo); end
      checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL divovf_div_zero: got %b want 0", div_zero); end
      @(posedge clk); #1;
   endtask

   task automatic test_div_zero();
      int lat; logic gap; logic [31:0] mh, ml;
      run_op(1'b1, 32'h451, 32'h20, lat, gap, mh, ml);
      checks++; if (hi !== 32'h11 || lo !== 32'h22) begin errors++; $display("FAIL divprep_result: got hi=%h lo=%h want hi=00000011 lo=00000022", hi, lo); end
      @(posedge clk); #1;
      run_op(1'b1, 32'd5, 32'd0, lat, gap, mh, ml);
      checks++; if (lat !== 1) begin errors++; $display("FAIL divzero_latency: got %0d want 1", lat); end
      checks++; if (div_zero !== 1'b1) begin errors++; $display("FAIL divzero_flag: got %b want 1", div_zero); end
      checks++; if (hi !== 32'h11 || lo !== 32'h22) begin errors++; $display("FAIL divzero_hilo_kept: got hi=%h lo=%h want hi=00000011 lo=00000022", hi, lo); end
      @(posedge clk); #1;
      checks++; if (div_zero !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL divzero_pulse: got dz=%b done=%b want 0 0", div_zero, done); end
   endtask

   task automatic test_back_to_back();
      int lat; logic gap; logic [31:0] mh, ml;
      run_op(1'b0, 32'd1000, 32'd1000, lat, gap, mh, ml);
      checks++; if (hi !== 32'h0 || lo !== 32'd1000000) begin errors++; $display("FAIL b2b_first: got %h_%h want 00000000_000f4240", hi, lo); end
      // Still in DONE here: the next start is taken without passing through IDLE.
      run_op(1'b1, 32'd100, 32'd7, lat, gap, mh, ml);
      checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_latency: got %0d want 33", lat); end
      checks++; if (lo !== 32'd14 || hi !== 32'd2) begin errors++; $display("FAIL b2b_second: got hi=%h lo=%h want hi=00000002 lo=0000000e", hi, lo); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_midop();
      int lat;
      logic seen_busy;
      // Cycle 0: start a mult, then reset sampled at cycle 10.
      start = 1'b1; op = 1'b0; a = 32'd3; b = 32'd5;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1; reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_mid_flags: got busy=%b done=%b want 0 0", busy, done); end
      checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL rst_mid_hilo: got %h_%h want 0_0", hi, lo); end
      // Cycle 11 idle, start sampled at cycle 12.
      @(posedge clk); #1;
      start = 1'b1; op = 1'b0; a = 32'h1234; b = 32'h10;
      @(posedge clk); #1;
      start = 1'b0; a = '0; b = '0;
      lat = 0; seen_busy = 1'b0;
      for (int k = 1; k <= 60; k++) begin
         if (k == 3) begin start = 1'b1; op = 1'b1; a = 32'd100; b = 32'd3; end
         if (k == 4) begin start = 1'b0; a = '0; b = '0; end
         @(posedge clk); #1;
         if (k == 3) seen_busy = busy;
         if (done) begin lat = k; break; end
      end
      checks++; if (seen_busy !== 1'b1) begin errors++; $display("FAIL rst_busy_at_c15: got %b want 1", seen_busy); end
      checks++; if (lat !== 33) begin errors++; $display("FAIL rst_restart_latency: got %0d want 33", lat); end
      checks++; if (hi !== 32'h0 || lo !== 32'h12340) begin errors++; $display("FAIL rst_restart_result: got %h_%h want 00000000_00012340", hi, lo); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_ignored_start: got done=%b busy=%b want 0 0", done, busy); end
   endtask

   initial begin
      test_reset();
      test_mult_basic();
      test_mult_edges();
      test_div_signs();
      test_div_zero();
      test_back_to_back();
      test_reset_midop();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
